vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter PIX_DIV, default 4: clk cycles per pixel (100 MHz clk gives a 25 MHz pixel rate); legal range 2..16.
REQ-002 SHALL have parameters H_TOTAL 800, H_SYNC 96, H_ACT_START 144, H_ACT_END 783: horizontal timing in pixels.
REQ-003 SHALL have parameters V_TOTAL 525, V_SYNC 2, V_ACT_START 35, V_ACT_END 514: vertical timing in lines.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port pix_en, output, 1 bit: one-clk pulse each time the pixel position advances.
REQ-007 SHALL have port hCount, output, 10 bits: current horizontal pixel position, 0..H_TOTAL-1.
REQ-008 SHALL have port vCount, output, 10 bits: current line, 0..V_TOTAL-1.
REQ-009 SHALL have port hSync, output, 1 bit: horizontal sync, active-low.
REQ-010 SHALL have port vSync, output, 1 bit: vertical sync, active-low.
REQ-011 SHALL have port bright, output, 1 bit: high inside the visible 640x480 window.
REQ-012 SHALL have port frame_tick, output, 1 bit: one-clk pulse at the start of each frame, used as the game-update clock enable.

Function
REQ-013 SHALL count clk cycles in a divider running 0..PIX_DIV-1.
REQ-014 SHALL assert pix_en for exactly one clk cycle when the divider equals PIX_DIV-1; the divider then wraps to 0.
REQ-015 SHALL change hCount and vCount only on clk edges where pix_en is high.
REQ-016 SHALL hold all counters and decoded outputs constant between pix_en pulses.
REQ-017 SHALL increment hCount by 1 on each pix_en; when hCount is H_TOTAL-1, hCount wraps to 0 and vCount increments.
REQ-018 SHALL wrap vCount from V_TOTAL-1 to 0 in the same edge that hCount wraps; counters never exceed their TOTAL-1.
REQ-019 SHALL drive hSync low when hCount < H_SYNC and high otherwise.
REQ-020 SHALL drive vSync low when vCount < V_SYNC and high otherwise.
REQ-021 SHALL drive bright high when H_ACT_START <= hCount <= H_ACT_END and V_ACT_START <= vCount <= V_ACT_END, and low otherwise.
REQ-022 SHALL register hSync, vSync and bright so they are glitch-free and always match the hCount/vCount values presented in the same cycle (zero relative latency).
REQ-023 SHALL pulse frame_tick high for exactly one clk cycle: the first cycle in which hCount=0 and vCount=0 are presented after a wrap from (799,524).
REQ-024 SHALL make the frame period exactly H_TOTAL*V_TOTAL*PIX_DIV = 1,680,000 clk cycles at default parameters.

Reset
REQ-025 SHALL set, on any clk edge with rst high: divider=0, hCount=0, vCount=0, hSync=0, vSync=0, bright=0, pix_en=0, frame_tick=0.
REQ-026 SHALL NOT pulse frame_tick as a result of reset, whether reset is applied at power-up or mid-frame.
REQ-027 SHALL produce the first pix_en on the PIX_DIV-th rising edge after rst deasserts, and hCount=1 on the following cycle.
REQ-028 SHALL give rst priority over pix_en when both occur in the same cycle.

Configuration
REQ-029 SHALL compile in frame_tick generation when macro VGA_FRAME_TICK_EN is defined, behaving as REQ-023.
REQ-030 SHALL tie frame_tick constant 0 when VGA_FRAME_TICK_EN is undefined, with no frame-detect logic; the port remains present and all other outputs are unchanged.

Verification
REQ-031 SHALL cover: rst high 3 cycles, then release -> hCount=0, vCount=0, hSync=0, vSync=0, bright=0; pix_en first high on the 4th edge; then hCount=1.
REQ-032 SHALL cover: free run on line 0 -> hSync=0 at hCount=95, 1 at hCount=96; vSync=0 on lines 0-1, 1 from vCount=2.
REQ-033 SHALL cover: visible-window corners -> bright=1 at (144,35) and (783,514); bright=0 at (143,35), (784,100) and (200,515).
REQ-034 SHALL cover: frame wrap from hCount=799, vCount=524 on pix_en -> (0,0) next cycle; frame_tick=1 for exactly 1 cycle; next tick 1,680,000 cycles later.
REQ-035 SHALL cover: rst pulsed for 1 cycle at hCount=400, vCount=200 -> all outputs reset next edge, no frame_tick, counting resumes per REQ-027.
REQ-036 SHALL cover: build without VGA_FRAME_TICK_EN, run 2 full frames -> frame_tick never 1; hCount, vCount, hSync, vSync and bright identical to the defined build.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, horizontal/vertical counters and registered sync/blank outputs.
// Define VGA_FRAME_TICK_EN to build the frame_tick start-of-frame pulse; otherwise frame_tick is tied low.
module vga_sync_gen #(
    parameter int PIX_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 783,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 514
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frame_tick
);

    logic [3:0] div_r;
    logic       div_wrap_s;
    logic       h_wrap_s;
    logic       v_wrap_s;
    logic [9:0] h_next_s;
    logic [9:0] v_next_s;

    // Next pixel position; the decoded outputs are registered from it so they line up with the counters.
    always_comb begin
        div_wrap_s = (div_r == 4'(PIX_DIV - 1));
        h_wrap_s   = (hCount == 10'(H_TOTAL - 1));
        v_wrap_s   = (vCount == 10'(V_TOTAL - 1));
        h_next_s   = hCount + 10'd1;
        v_next_s   = vCount;
        if (h_wrap_s) begin
            h_next_s = 10'd0;
            if (v_wrap_s) begin
                v_next_s = 10'd0;
            end else begin
                v_next_s = vCount + 10'd1;
            end
        end else begin
            h_next_s = hCount + 10'd1;
        end
    end

    // Clock divider and one-clk pixel enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r  <= 4'd0;
            pix_en <= 1'b0;
        end else begin
            pix_en <= div_wrap_s;
            if (div_wrap_s) begin
                div_r <= 4'd0;
            end else begin
                div_r <= div_r + 4'd1;
            end
        end
    end

    // Position counters with sync and visible-window decode, all advancing together on pix_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            hCount <= 10'd0;
            vCount <= 10'd0;
            hSync  <= 1'b0;
            vSync  <= 1'b0;
            bright <= 1'b0;
        end else if (pix_en) begin
            hCount <= h_next_s;
            vCount <= v_next_s;
            hSync  <= (h_next_s >= 10'(H_SYNC));
            vSync  <= (v_next_s >= 10'(V_SYNC));
            bright <= (h_next_s >= 10'(H_ACT_START)) && (h_next_s <= 10'(H_ACT_END)) &&
                      (v_next_s >= 10'(V_ACT_START)) && (v_next_s <= 10'(V_ACT_END));
        end else begin
            hCount <= hCount;
            vCount <= vCount;
            hSync  <= hSync;
            vSync  <= vSync;
            bright <= bright;
        end
    end

`ifdef VGA_FRAME_TICK_EN
    // Start-of-frame pulse: set only by the counter wrap, never by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= pix_en & h_wrap_s & v_wrap_s;
        end
    end
`else
    assign frame_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default horizontal timing with a shortened 6-line frame.
module tb_vga_sync_gen;

    localparam int PIX_DIV = 4;
    localparam int V_TOTAL = 6;
    localparam int FRAME_CYCLES = 800 * V_TOTAL * PIX_DIV;  // 19200
`ifdef VGA_FRAME_TICK_EN
    localparam int EXP_TICK = 1;
`else
    localparam int EXP_TICK = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       hSync;
    logic       vSync;
    logic       bright;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    vga_sync_gen #(
        .PIX_DIV(PIX_DIV), .H_TOTAL(800), .H_SYNC(96), .H_ACT_START(144), .H_ACT_END(783),
        .V_TOTAL(V_TOTAL), .V_SYNC(2), .V_ACT_START(3), .V_ACT_END(4)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hCount(hCount), .vCount(vCount),
        .hSync(hSync), .vSync(vSync), .bright(bright), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input string tag, input int h, input int v);
        int n = 0;
        while (!(int'(hCount) == h && int'(vCount) == v) && n < 25000) begin
            step();
            n++;
        end
        chk({tag, "_reached"}, 32'(n < 25000), 32'd1);
    endtask

    // Called right after rst has been dropped following the sampling edge.
    task automatic check_release(input string tag);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk({tag, "_pix_en_early"}, 32'(pix_en), 32'd0);
            chk({tag, "_h_hold"}, 32'(hCount), 32'd0);
            chk({tag, "_tick_quiet"}, 32'(frame_tick), 32'd0);
        end
        step();
        chk({tag, "_pix_en_4th"}, 32'(pix_en), 32'd1);
        chk({tag, "_h_still0"}, 32'(hCount), 32'd0);
        step();
        chk({tag, "_pix_en_drop"}, 32'(pix_en), 32'd0);
        chk({tag, "_h_is1"}, 32'(hCount), 32'd1);
    endtask

    initial begin
        int n;
        int ticks;
        bit left;

        // Reset held for three edges
        rst = 1'b1;
        repeat (3) step();
        chk("rst_h", 32'(hCount), 32'd0);
        chk("rst_v", 32'(vCount), 32'd0);
        chk("rst_hsync", 32'(hSync), 32'd0);
        chk("rst_vsync", 32'(vSync), 32'd0);
        chk("rst_bright", 32'(bright), 32'd0);
        chk("rst_pix_en", 32'(pix_en), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        rst = 1'b0;
        check_release("rel");

        // Counters hold between pix_en pulses
        for (int k = 0; k < 2; k++) begin
            step();
            chk("hold_h", 32'(hCount), 32'd1);
        end
        step();
        chk("hold_pix_en", 32'(pix_en), 32'd1);
        chk("hold_h_last", 32'(hCount), 32'd1);
        step();
        chk("adv_h2", 32'(hCount), 32'd2);

        // Horizontal and vertical sync edges
        wait_pos("h95", 95, 0);
        chk("hsync_95", 32'(hSync), 32'd0);
        chk("vsync_l0", 32'(vSync), 32'd0);
        wait_pos("h96", 96, 0);
        chk("hsync_96", 32'(hSync), 32'd1);
        wait_pos("l1", 0, 1);
        chk("vsync_l1", 32'(vSync), 32'd0);
        chk("hsync_l1_h0", 32'(hSync), 32'd0);
        wait_pos("l2", 0, 2);
        chk("vsync_l2", 32'(vSync), 32'd1);

        // Visible-window corners
        wait_pos("c143", 143, 3);
        chk("bright_143_3", 32'(bright), 32'd0);
        wait_pos("c144", 144, 3);
        chk("bright_144_3", 32'(bright), 32'd1);
        wait_pos("c784", 784, 3);
        chk("bright_784_3", 32'(bright), 32'd0);
        wait_pos("c783", 783, 4);
        chk("bright_783_4", 32'(bright), 32'd1);
        wait_pos("c200", 200, 5);
        chk("bright_200_5", 32'(bright), 32'd0);

        // Frame wrap and frame period
        wait_pos("pre_wrap", 799, 5);
        chk("pre_wrap_tick", 32'(frame_tick), 32'd0);
        chk("pre_wrap_hsync", 32'(hSync), 32'd1);
        n = 0;
        while (hCount == 10'd799 && n < 8) begin
            step();
            n++;
        end
        chk("wrap_h", 32'(hCount), 32'd0);
        chk("wrap_v", 32'(vCount), 32'd0);
        chk("wrap_tick", 32'(frame_tick), 32'(EXP_TICK));
        chk("wrap_hsync", 32'(hSync), 32'd0);
        chk("wrap_vsync", 32'(vSync), 32'd0);
        chk("wrap_bright", 32'(bright), 32'd0);
        step();
        chk("tick_one_cycle", 32'(frame_tick), 32'd0);
        chk("wrap_h_hold", 32'(hCount), 32'd0);
        n = 1;
        left = 1'b0;
        ticks = 0;
        while (n < 25000) begin
            step();
            n++;
            if (hCount != 10'd0 || vCount != 10'd0) left = 1'b1;
            else if (left) break;
            if (frame_tick) ticks++;
        end
        chk("frame_period", 32'(n), 32'(FRAME_CYCLES));
        chk("no_stray_tick", 32'(ticks), 32'd0);
        chk("second_tick", 32'(frame_tick), 32'(EXP_TICK));

        // Mid-frame reset, asserted in a cycle where pix_en is high
        wait_pos("mid", 400, 2);
        n = 0;
        while (pix_en !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk("mid_pix_en_seen", 32'(pix_en), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_h", 32'(hCount), 32'd0);
        chk("mid_rst_v", 32'(vCount), 32'd0);
        chk("mid_rst_hsync", 32'(hSync), 32'd0);
        chk("mid_rst_vsync", 32'(vSync), 32'd0);
        chk("mid_rst_bright", 32'(bright), 32'd0);
        chk("mid_rst_pix_en", 32'(pix_en), 32'd0);
        chk("mid_rst_tick", 32'(frame_tick), 32'd0);
        check_release("mid_rel");
        wait_pos("post_rst", 96, 0);
        chk("post_rst_hsync", 32'(hSync), 32'd1);
        chk("post_rst_tick", 32'(frame_tick), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
